// File: rtl/mult_seq_digit_grid.sv
// Sequential unsigned WIDTH x WIDTH multiplier. One DIGIT x DIGIT multiplier
// is reused over N*N cycles (N = WIDTH/DIGIT). Each cycle it forms one digit
// partial product, shifts it into place and adds it to a 2*WIDTH accumulator.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE.
// P is held stable until the consumer takes it with out_ready.
module mult_seq_digit_grid #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(PW) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    i_q, i_d;
  logic [IW-1:0]    j_q, j_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    p_q, p_d;

  // Datapath signals for the current grid cell (i = inner, j = outer).
  logic [SW-1:0]      shift_a, shift_b, shamt;
  logic [WIDTH-1:0]   a_sh, b_sh;
  logic [DIGIT-1:0]   a_dig, b_dig;
  logic [2*DIGIT-1:0] dig_prod;
  logic [PW-1:0]      term;
  logic               i_last, last_cell;

  // Select the digits, form the digit product and weight it by (i+j)*DIGIT.
  always_comb begin
    shift_a   = SW'(i_q) * SW'(DIGIT);
    shift_b   = SW'(j_q) * SW'(DIGIT);
    shamt     = shift_a + shift_b;
    a_sh      = a_q >> shift_a;
    b_sh      = b_q >> shift_b;
    a_dig     = a_sh[DIGIT-1:0];
    b_dig     = b_sh[DIGIT-1:0];
    dig_prod  = (2*DIGIT)'(a_dig) * (2*DIGIT)'(b_dig);
    term      = PW'(dig_prod) << shamt;
    i_last    = (i_q == IW'(N - 1));
    last_cell = i_last && (j_q == IW'(N - 1));
  end

  // State register and datapath flops; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  // Next-state and next-datapath logic: accept, walk the grid, hand off.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_q + term;
        if (last_cell) begin
          p_d     = acc_q + term;
          i_d     = '0;
          j_d     = '0;
          state_d = S_DONE;
        end else if (i_last) begin
          i_d = '0;
          j_d = j_q + 1'b1;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    P         = p_q;
  end

endmodule
